// File: rtl/lamp_fader_pkg.sv
// Shared types and helpers for the lamp fader output stage.
package lamp_pkg;

    typedef enum logic [1:0] {
        OFF,
        FADE_UP,
        ON,
        FADE_DOWN
    } fader_state_t;

    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/lamp_fader_pwm_gen.sv
// Free-running PWM generator with registered output.
// LAMP_FADER_GAMMA_EN adds a registered (l*l+l)>>PWM_BITS gamma stage before the compare.
module pwm_gen
    import lamp_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

`ifdef LAMP_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] lvl_w;
    logic [2*PWM_BITS-1:0] sq;
    logic [PWM_BITS-1:0]   duty_q;

    // l*l + l stays below 2**(2*PWM_BITS), so the top half is the gamma duty.
    always_comb begin
        lvl_w = {{PWM_BITS{1'b0}}, level};
        sq    = lvl_w * lvl_w + lvl_w;
    end

    always_ff @(posedge clk) begin
        if (rst) duty_q <= '0;
        else     duty_q <= sq[2*PWM_BITS-1:PWM_BITS];
    end

    always_comb duty = duty_q;
`else
    always_comb duty = level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            pwm_out <= (duty == MAX_LEVEL) || (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/lamp_fader.sv
// Lamp output stage: ramps brightness linearly on lamp_req changes and drives a PWM.
// Optional gamma duty mapping is enabled with LAMP_FADER_GAMMA_EN.
module lamp_fader
    import lamp_pkg::*;
#(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned FADE_STEP_T = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lamp_req,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                at_full,
    output logic                dark
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(max_level(PWM_BITS));
    localparam logic [15:0]         STEP_LAST = 16'(FADE_STEP_T - 1);

    fader_state_t        state, state_n;
    logic [15:0]         step_cnt, step_cnt_n;
    logic [PWM_BITS-1:0] level_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            level    <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            step_cnt <= step_cnt_n;
        end
    end

    // A reversal takes priority over a step due on the same edge.
    always_comb begin
        state_n    = state;
        level_n    = level;
        step_cnt_n = '0;
        case (state)
            OFF: if (lamp_req) state_n = FADE_UP;
            ON:  if (!lamp_req) state_n = FADE_DOWN;
            FADE_UP: begin
                if (!lamp_req) begin
                    state_n = FADE_DOWN;
                end else if (step_cnt == STEP_LAST) begin
                    if (level >= MAX_LEVEL - PWM_BITS'(1)) begin
                        level_n = MAX_LEVEL;
                        state_n = ON;
                    end else begin
                        level_n = level + PWM_BITS'(1);
                    end
                end else begin
                    step_cnt_n = step_cnt + 16'd1;
                end
            end
            FADE_DOWN: begin
                if (lamp_req) begin
                    state_n = FADE_UP;
                end else if (step_cnt == STEP_LAST) begin
                    if (level <= PWM_BITS'(1)) begin
                        level_n = '0;
                        state_n = OFF;
                    end else begin
                        level_n = level - PWM_BITS'(1);
                    end
                end else begin
                    step_cnt_n = step_cnt + 16'd1;
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_comb begin
        busy    = (state == FADE_UP) || (state == FADE_DOWN);
        at_full = (state == ON) && (level == MAX_LEVEL);
        dark    = (state == OFF) && (level == '0);
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .level  (level),
        .pwm_out(pwm_out)
    );

endmodule
